// File: rtl/cnn_mem_reader.sv
// cnn_mem_reader: burst read streamer for CNNmemory.
// A burst (base word address, length) is fetched as WORDS_PER_READ-word lines.
// Each line is serialised onto a valid/ready word stream.
// Lines are fetched only when the previous line has drained, which leaves a
// fixed two-cycle bubble (FETCH, CAPTURE) between lines.
module cnn_mem_reader #(
   parameter int DATA_W         = 16,
   parameter int WORDS_PER_READ = 25,
   parameter int ADDR_W         = 16,
   parameter int LEN_W          = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [ADDR_W-1:0]                req_base,
   input  logic [LEN_W-1:0]                 req_len,
   output logic                             mem_read_en,
   output logic [ADDR_W-1:0]                mem_address,
   input  logic [DATA_W*WORDS_PER_READ-1:0] mem_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_W-1:0]                out_data,
   output logic                             out_last,
   output logic                             busy,
   output logic                             done
);

   // idx and line_cnt must be able to hold WORDS_PER_READ itself
   localparam int CNT_W = $clog2(WORDS_PER_READ + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_STREAM  = 2'd3;

   logic [1:0]                                state_q, state_d;
   logic [ADDR_W-1:0]                         cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]                          remaining_q, remaining_d;
   logic [WORDS_PER_READ-1:0][DATA_W-1:0]     line_q, line_d;
   logic [CNT_W-1:0]                          line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0]                          idx_q, idx_d;
   logic                                      done_q, done_d;

   // Outputs decode straight from state so reset clears them asynchronously
   assign req_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign mem_read_en = (state_q == S_FETCH);
   assign mem_address = (state_q == S_FETCH) ? cur_addr_q : '0;
   assign out_valid   = (state_q == S_STREAM);
   assign out_data    = (state_q == S_STREAM) ? line_q[idx_q] : '0;
   assign out_last    = (state_q == S_STREAM) && (remaining_q == LEN_W'(1));
   assign done        = done_q;

   // Next-state and datapath update for the burst sequencer
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      line_d      = line_q;
      line_cnt_d  = line_cnt_q;
      idx_d       = idx_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               cur_addr_d  = req_base;
               remaining_d = req_len;
               // Zero-length burst completes without touching memory
               if (req_len == '0) done_d  = 1'b1;
               else               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // mem_data is valid now, one cycle after the read strobe
            line_d = mem_data;
            if (remaining_q < LEN_W'(WORDS_PER_READ))
               line_cnt_d = CNT_W'(remaining_q);
            else
               line_cnt_d = CNT_W'(WORDS_PER_READ);
            idx_d   = '0;
            state_d = S_STREAM;
         end
         default: begin // S_STREAM, remaining_q >= 1 here
            if (out_ready) begin
               idx_d       = idx_q + CNT_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
               if (idx_q == line_cnt_q - CNT_W'(1)) begin
                  if (remaining_q == LEN_W'(1)) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     // Wraps modulo 2^ADDR_W by construction
                     cur_addr_d = cur_addr_q + ADDR_W'(WORDS_PER_READ);
                     state_d    = S_FETCH;
                  end
               end
            end
         end
      endcase
   end

   // State registers; reset aborts any burst and drops the line buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         line_q      <= '0;
         line_cnt_q  <= '0;
         idx_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         line_q      <= line_d;
         line_cnt_q  <= line_cnt_d;
         idx_q       <= idx_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_cnn_mem_reader.sv
// Bench for cnn_mem_reader: memory model, scoreboard of expected words and
// expected line reads, per-scenario tasks with inline checks.
module tb_cnn_mem_reader;
   localparam int DW = 16;
   localparam int WPR = 25;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [15:0]       req_base = '0;
   logic [15:0]       req_len = '0;
   logic              mem_read_en;
   logic [15:0]       mem_address;
   logic [DW*WPR-1:0] mem_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [15:0]       out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   int total = 0;
   int bad = 0;
   int mode = 0; // 0: out_ready=1, 1: toggle, 2: random

   logic [15:0] exp_data_q[$];
   logic        exp_last_q[$];
   logic [15:0] exp_addr_q[$];

   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        prev_last = 1'b0;

   cnn_mem_reader dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_base(req_base), .req_len(req_len), .mem_read_en(mem_read_en),
      .mem_address(mem_address), .mem_data(mem_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return a * 16'd31 + 16'h1234;
   endfunction

   // Registered-read memory; garbage when not read so late capture shows up
   always @(posedge clk) begin
      for (int k = 0; k < WPR; k++)
         mem_data[k*DW +: DW] <= mem_read_en ? memf(mem_address + 16'(k)) : 16'hDEAD;
   end

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mode == 0)      out_ready = 1'b1;
         else if (mode == 1) out_ready = ~out_ready;
         else                out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard monitor: reads, streamed words, stall stability
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            if (!(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last)) begin
               bad++;
               $display("FAIL stall_hold: valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                        out_valid, out_data, out_last, prev_data, prev_last);
            end
         end
         if (mem_read_en) begin
            total++;
            if (exp_addr_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_read: addr=%0d, no read expected", mem_address);
            end else begin
               logic [15:0] ea;
               ea = exp_addr_q.pop_front();
               if (mem_address !== ea) begin
                  bad++;
                  $display("FAIL read_addr: got %0d need %0d", mem_address, ea);
               end
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_data_q.size() == 0) begin
               bad++;
               $display("FAIL extra_word: got %h, no word expected", out_data);
            end else begin
               logic [15:0] ed;
               logic        el;
               ed = exp_data_q.pop_front();
               el = exp_last_q.pop_front();
               if (out_data !== ed || out_last !== el) begin
                  bad++;
                  $display("FAIL word: got data=%h last=%b need data=%h last=%b",
                           out_data, out_last, ed, el);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic push_exp(input logic [15:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         exp_data_q.push_back(memf(base + 16'(i)));
         exp_last_q.push_back(i == len - 1);
      end
      for (int l = 0; l < (len + WPR - 1) / WPR; l++)
         exp_addr_q.push_back(base + 16'(l * WPR));
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({mem_read_en, mem_address, out_valid, out_data, out_last, busy, done} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: rd=%b addr=%h v=%b d=%h l=%b busy=%b done=%b, need all 0",
                  mem_read_en, mem_address, out_valid, out_data, out_last, busy, done);
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: req_ready=%b busy=%b need 1 0", req_ready, busy);
      end
   endtask

   task automatic run_burst(input logic [15:0] base, input int len, input int m);
      int nl, first_rd, first_v, done_c, busy_n;
      mode = m;
      nl = (len + WPR - 1) / WPR;
      push_exp(base, len);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_base = base; req_len = 16'(len);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL req_ready_idle: got %b need 1", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      first_rd = -1; first_v = -1; done_c = -1; busy_n = 0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (mem_read_en && first_rd < 0) first_rd = c;
         if (out_valid && first_v < 0) first_v = c;
         if (busy) busy_n++;
         if (done) begin done_c = c; break; end
      end
      total++;
      if (done_c < 0) begin
         bad++;
         $display("FAIL done_timeout: base=%0d len=%0d no done", base, len);
      end
      total++;
      if (exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
         bad++;
         $display("FAIL burst_drain: base=%0d len=%0d left words=%0d reads=%0d need 0 0",
                  base, len, exp_data_q.size(), exp_addr_q.size());
      end
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_idle: req_ready=%b busy=%b need 1 0", req_ready, busy);
      end
      if (len > 0) begin
         total++;
         if (first_rd != 1 || first_v != 3) begin
            bad++;
            $display("FAIL latency: read@%0d valid@%0d need 1 3", first_rd, first_v);
         end
      end else begin
         total++;
         if (first_rd != -1) begin
            bad++;
            $display("FAIL len0_read: read@%0d need none", first_rd);
         end
      end
      if (m == 0) begin
         total++;
         if (done_c != 2*nl + len + 1 || busy_n != 2*nl + len) begin
            bad++;
            $display("FAIL timing: done@%0d busy=%0d need done@%0d busy=%0d",
                     done_c, busy_n, 2*nl + len + 1, 2*nl + len);
         end
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse: got %b need 0", done);
      end
      mode = 0;
   endtask

   task automatic test_back_to_back();
      int seen;
      mode = 0;
      push_exp(16'd100, 3);
      push_exp(16'd200, 4);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_base = 16'd100; req_len = 16'd3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      total++;
      if (!seen || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_done: done_seen=%0d req_ready=%b need 1 1", seen, req_ready);
      end
      req_valid = 1'b1; req_base = 16'd200; req_len = 16'd4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (mem_read_en !== 1'b1) begin
         bad++;
         $display("FAIL b2b_accept: mem_read_en=%b need 1", mem_read_en);
      end
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      total++;
      if (!seen || exp_data_q.size() != 0 || exp_addr_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain: done_seen=%0d words=%0d reads=%0d need 1 0 0",
                  seen, exp_data_q.size(), exp_addr_q.size());
      end
   endtask

   task automatic test_reset_mid_stream();
      mode = 0;
      push_exp(16'd0, 60);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_base = 16'd0; req_len = 16'd60;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || mem_read_en !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: valid=%b busy=%b rd=%b done=%b need 0 0 0 0",
                  out_valid, busy, mem_read_en, done);
      end
      exp_data_q.delete();
      exp_last_q.delete();
      exp_addr_q.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      run_burst(16'd5, 2, 0);
   endtask

   initial begin
      test_reset();
      run_burst(16'd0, 3, 0);
      run_burst(16'd0, 50, 0);
      run_burst(16'd50704, 26, 0);
      run_burst(16'd300, 10, 1);
      run_burst(16'd7, 0, 0);
      run_burst(16'd65530, 30, 0);
      run_burst(16'd1000, 37, 2);
      test_back_to_back();
      test_reset_mid_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
